// File: rtl/character_mover_pkg.sv
// Shared constants and types for the lane-based character mover.
// Holds the FSM state encoding, lane bounds, default home lane and phase
// length, colour constants and a helper that identifies pixel-phase states.
package character_mover_pkg;

  localparam int unsigned POS_W         = 4;
  localparam int unsigned PHASE_W       = 6;
  localparam int unsigned COLOUR_W      = 3;

  localparam int unsigned PHASE_LEN_DEF = 47;
  localparam int unsigned HOME_POS_DEF  = 4;
  // First phase count with valid downstream coordinates (2-cycle latency)
  localparam int unsigned PLOT_FIRST    = 2;

  localparam logic [POS_W-1:0]    LANE_MIN     = POS_W'(0);
  localparam logic [POS_W-1:0]    LANE_MAX     = POS_W'(8);

  localparam logic [COLOUR_W-1:0] COLOUR_ERASE = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_DRAW  = 3'b111;

  typedef enum logic [2:0] {
    ST_INIT_DRAW = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ERASE     = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_DRAW      = 3'd4
  } state_e;

  // True for states that sweep the sprite pixels with the phase counter
  function automatic logic is_phase_state(input state_e s);
    return (s == ST_ERASE) || (s == ST_DRAW) || (s == ST_INIT_DRAW);
  endfunction

endpackage

// File: rtl/character_mover_edge_detect.sv
// Per-bit rising-edge detector against a registered previous level.
// Ports: Clock, Reset (sync, active-low), level_i (levels to watch),
//        rise_c_o (combinational: high while level_i=1 and previous level=0).
module edge_detect #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] rise_c_o
);

  logic [WIDTH-1:0] prev_q;

  // Previous level, refreshed every cycle regardless of any consumer state
  always_ff @(posedge Clock) begin
    if (!Reset) prev_q <= '0;
    else        prev_q <= level_i;
  end

  assign rise_c_o = level_i & ~prev_q;

endmodule

// File: rtl/character_mover.sv
// Moves a character sprite between lanes 0..8: on an accepted left/right
// request it erases the sprite at the old lane, steps the lane, and redraws.
// Ports: Clock, Reset (sync, active-low), MoveLeft/MoveRight (level requests),
//        CurrState (lane to the drawing stage), Plot (VGA write enable),
//        Colour (pixel colour), Busy (high outside IDLE).
module character_mover
  import character_mover_pkg::*;
#(
  parameter int unsigned PHASE_LEN = PHASE_LEN_DEF,
  parameter int unsigned HOME_POS  = HOME_POS_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                MoveLeft,
  input  logic                MoveRight,
  output logic [POS_W-1:0]    CurrState,
  output logic                Plot,
  output logic [COLOUR_W-1:0] Colour,
  output logic                Busy
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_LEN - 1);
  localparam logic [PHASE_W-1:0] PHASE_PLOT = PHASE_W'(PLOT_FIRST);
  localparam logic [POS_W-1:0]   HOME_LANE  = POS_W'(HOME_POS);

  logic [1:0] rise; // [0] left, [1] right

  edge_detect #(.WIDTH(2)) u_edge_detect (
    .Clock    (Clock),
    .Reset    (Reset),
    .level_i  ({MoveRight, MoveLeft}),
    .rise_c_o (rise)
  );

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_right_q, dir_right_d;
  logic                 plot_q, plot_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  logic                 busy_q, busy_d;
  logic                 phase_done;

  assign phase_done = (phase_q == PHASE_LAST);

  // Next-state logic; outputs are derived from the next state so that the
  // registered Plot/Colour/Busy line up with the registered phase counter.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    dir_right_d = dir_right_q;

    case (state_q)
      ST_INIT_DRAW, ST_DRAW, ST_ERASE: begin
        if (phase_done) begin
          state_d = (state_q == ST_ERASE) ? ST_UPDATE : ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_IDLE: begin
        phase_d = '0;
        // Exactly one edge and a legal target; everything else is dropped
        if (rise[0] && !rise[1] && (pos_q != LANE_MIN)) begin
          state_d     = ST_ERASE;
          dir_right_d = 1'b0;
        end else if (rise[1] && !rise[0] && (pos_q != LANE_MAX)) begin
          state_d     = ST_ERASE;
          dir_right_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        pos_d   = dir_right_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        state_d = ST_DRAW;
        phase_d = '0;
      end
      default: begin
        state_d = ST_INIT_DRAW;
        phase_d = '0;
      end
    endcase

    plot_d   = is_phase_state(state_d) && (phase_d >= PHASE_PLOT);
    colour_d = COLOUR_ERASE;
    if ((state_d == ST_DRAW) || (state_d == ST_INIT_DRAW)) colour_d = COLOUR_DRAW;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any phase in progress
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_INIT_DRAW;
      phase_q     <= '0;
      pos_q       <= HOME_LANE;
      dir_right_q <= 1'b0;
      plot_q      <= 1'b0;
      colour_q    <= COLOUR_ERASE;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      dir_right_q <= dir_right_d;
      plot_q      <= plot_d;
      colour_q    <= colour_d;
      busy_q      <= busy_d;
    end
  end

  assign CurrState = pos_q;
  assign Plot      = plot_q;
  assign Colour    = colour_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_character_mover.sv
// Scoreboard bench for character_mover: every expected Plot pulse (cycle,
// lane, colour) is queued when stimulus is applied and matched in order as
// the DUT plots.
module tb_character_mover;

  localparam int unsigned PHASE_LEN = 47;
  localparam int unsigned HOME_POS  = 4;
  localparam int          NPIX      = 45;
  localparam int          MOVE_LEN  = 96;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       MoveLeft = 1'b0;
  logic       MoveRight = 1'b0;
  logic [3:0] CurrState;
  logic       Plot;
  logic [2:0] Colour;
  logic       Busy;

  typedef struct {
    int         cyc;
    logic [3:0] lane;
    logic [2:0] colour;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_pos = HOME_POS;

  character_mover #(.PHASE_LEN(PHASE_LEN), .HOME_POS(HOME_POS)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MoveLeft  (MoveLeft),
    .MoveRight (MoveRight),
    .CurrState (CurrState),
    .Plot      (Plot),
    .Colour    (Colour),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  // Advance one cycle; Plot pulses are matched against the scoreboard at negedge
  task automatic step();
    exp_t e;
    @(negedge Clock);
    if (Plot === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL plot_unexpected: cyc=%0d lane=%0d colour=%0d, required no Plot", cyc, CurrState, Colour);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || CurrState !== e.lane || Colour !== e.colour) begin
          bad++;
          $display("FAIL plot_match: got cyc=%0d lane=%0d colour=%0d, required cyc=%0d lane=%0d colour=%0d",
                   cyc, CurrState, Colour, e.cyc, e.lane, e.colour);
        end
      end
    end
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic push_run(input int first, input int lane, input logic [2:0] colour, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc    = first + i;
      e.lane   = 4'(lane);
      e.colour = colour;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    int c;
    Reset = 1'b0;
    step();
    step();
    total++;
    if ({CurrState, Plot, Colour, Busy} !== {4'(HOME_POS), 1'b0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: got lane=%0d plot=%0b colour=%0d busy=%0b, required lane=4 plot=0 colour=0 busy=1",
               CurrState, Plot, Colour, Busy);
    end
    c = cyc;
    Reset = 1'b1;
    push_run(c + 2, HOME_POS, 3'b111, NPIX);
    goto(c + 46);
    total++;
    if (Busy !== 1'b1 || CurrState !== 4'(HOME_POS)) begin
      bad++;
      $display("FAIL init_draw_busy: got busy=%0b lane=%0d, required busy=1 lane=4", Busy, CurrState);
    end
    goto(c + 47);
    total++;
    if (Busy !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL init_draw_done: got busy=%0b pending=%0d, required busy=0 pending=0", Busy, sb.size());
    end
    model_pos = HOME_POS;
  endtask

  // One pulsed, legal move with lane/busy checks at the phase boundaries
  task automatic move_pulse(input bit right);
    int c;
    int newpos;
    c = cyc;
    newpos = right ? model_pos + 1 : model_pos - 1;
    push_run(c + 3, model_pos, 3'b000, NPIX);
    push_run(c + 51, newpos, 3'b111, NPIX);
    if (right) MoveRight = 1'b1; else MoveLeft = 1'b1;
    step();
    MoveRight = 1'b0;
    MoveLeft = 1'b0;
    goto(c + 47);
    total++;
    if (CurrState !== 4'(model_pos) || Busy !== 1'b1) begin
      bad++;
      $display("FAIL erase_lane: got lane=%0d busy=%0b, required lane=%0d busy=1", CurrState, Busy, model_pos);
    end
    goto(c + 49);
    total++;
    if (CurrState !== 4'(newpos)) begin
      bad++;
      $display("FAIL draw_lane: got lane=%0d, required lane=%0d", CurrState, newpos);
    end
    goto(c + MOVE_LEN);
    total++;
    if (Busy !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL move_done: got busy=%0b pending=%0d, required busy=0 pending=0", Busy, sb.size());
    end
    model_pos = newpos;
  endtask

  task automatic test_move_right();
    move_pulse(1'b1);
  endtask

  task automatic test_move_left();
    move_pulse(1'b0);
  endtask

  task automatic test_hold_and_ignore();
    int c;
    c = cyc;
    push_run(c + 3, model_pos, 3'b000, NPIX);
    push_run(c + 51, model_pos + 1, 3'b111, NPIX);
    MoveRight = 1'b1;
    goto(c + 20);
    MoveLeft = 1'b1;
    step();
    MoveLeft = 1'b0;
    goto(c + 60);
    MoveLeft = 1'b1;
    step();
    MoveLeft = 1'b0;
    goto(c + MOVE_LEN);
    total++;
    if (Busy !== 1'b0 || CurrState !== 4'(model_pos + 1)) begin
      bad++;
      $display("FAIL hold_one_move: got busy=%0b lane=%0d, required busy=0 lane=%0d", Busy, CurrState, model_pos + 1);
    end
    goto(c + 200);
    MoveRight = 1'b0;
    goto(c + 210);
    total++;
    if (Busy !== 1'b0 || CurrState !== 4'(model_pos + 1) || sb.size() != 0) begin
      bad++;
      $display("FAIL hold_release: got busy=%0b lane=%0d pending=%0d, required busy=0 lane=%0d pending=0",
               Busy, CurrState, sb.size(), model_pos + 1);
    end
    model_pos = model_pos + 1;
  endtask

  // Request that must be dropped: Busy stays low, no Plot, lane unchanged
  task automatic dropped_request(input bit left, input bit right);
    MoveLeft = left;
    MoveRight = right;
    step();
    MoveLeft = 1'b0;
    MoveRight = 1'b0;
    for (int i = 0; i < 60; i++) begin
      total++;
      if (Busy !== 1'b0) begin
        bad++;
        $display("FAIL dropped_busy: cycle %0d got busy=%0b, required 0", i, Busy);
      end
      step();
    end
    total++;
    if (CurrState !== 4'(model_pos)) begin
      bad++;
      $display("FAIL dropped_lane: got lane=%0d, required lane=%0d", CurrState, model_pos);
    end
  endtask

  task automatic test_simultaneous();
    dropped_request(1'b1, 1'b1);
  endtask

  task automatic test_boundaries();
    while (model_pos > 0) move_pulse(1'b0);
    dropped_request(1'b1, 1'b0);
    while (model_pos < 8) move_pulse(1'b1);
    dropped_request(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_erase();
    int c;
    c = cyc;
    // ERASE phase p is at cycle c+1+p; plots for phases 2..20 precede the reset
    push_run(c + 3, model_pos, 3'b000, 19);
    MoveLeft = 1'b1;
    step();
    MoveLeft = 1'b0;
    goto(c + 21);
    Reset = 1'b0;
    step();
    total++;
    if ({CurrState, Plot, Colour, Busy} !== {4'(HOME_POS), 1'b0, 3'b000, 1'b1} || sb.size() != 0) begin
      bad++;
      $display("FAIL reset_abort: got lane=%0d plot=%0b colour=%0d busy=%0b pending=%0d, required lane=4 plot=0 colour=0 busy=1 pending=0",
               CurrState, Plot, Colour, Busy, sb.size());
    end
    c = cyc;
    Reset = 1'b1;
    push_run(c + 2, HOME_POS, 3'b111, NPIX);
    goto(c + 47);
    total++;
    if (Busy !== 1'b0 || CurrState !== 4'(HOME_POS) || sb.size() != 0) begin
      bad++;
      $display("FAIL reset_redraw: got busy=%0b lane=%0d pending=%0d, required busy=0 lane=4 pending=0",
               Busy, CurrState, sb.size());
    end
    model_pos = HOME_POS;
  endtask

  initial begin
    @(posedge Clock);
    #1;
    cyc = 1;
    test_reset();
    test_move_right();
    test_move_left();
    test_hold_and_ignore();
    test_simultaneous();
    test_boundaries();
    test_reset_mid_erase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/character_mover.md
CHARACTER_MOVER -- requirements
Module: character_mover

Interface
REQ-001 SHALL have parameter PHASE_LEN, default 47, meaning cycles per erase/draw phase (45 pixels + 2 pipeline cycles).
REQ-002 SHALL have parameter HOME_POS, default 4, meaning the lane restored on reset.
REQ-003 SHALL have port Clock, input, 1, system clock; all logic on posedge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-low.
REQ-005 SHALL have port MoveLeft, input, 1, synchronised level request to move one lane left.
REQ-006 SHALL have port MoveRight, input, 1, synchronised level request to move one lane right.
REQ-007 SHALL have port CurrState, output, 4, lane index 0..8 driven to the downstream character-drawing stage.
REQ-008 SHALL have port Plot, output, 1, VGA write enable.
REQ-009 SHALL have port Colour, output, 3, VGA pixel colour (3'b000 erase, 3'b111 draw).
REQ-010 SHALL have port Busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL use FSM states INIT_DRAW, IDLE, ERASE, UPDATE, DRAW.
REQ-012 SHALL detect rising edges on MoveLeft/MoveRight against a registered previous level, updated every cycle in every state.
REQ-013 In IDLE, an edge on exactly one input SHALL be accepted only if the move is legal (left: pos>0; right: pos<8); an accepted move SHALL go to ERASE next cycle.
REQ-014 Simultaneous edges on both inputs, illegal moves at lane 0/8, and edges outside IDLE SHALL be dropped (no queueing, no state change).
REQ-015 ERASE and DRAW SHALL each last exactly PHASE_LEN cycles, timed by a 6-bit phase counter cleared on phase entry.
REQ-016 CurrState SHALL hold the old lane throughout ERASE and the new lane throughout DRAW/INIT_DRAW.
REQ-017 Plot SHALL be 1 for phase counter values 2..46 inclusive (45 cycles) and 0 otherwise, compensating the 2-cycle coordinate latency of the downstream stage.
REQ-018 Colour SHALL be 3'b000 in ERASE and 3'b111 in DRAW/INIT_DRAW; 3'b000 elsewhere.
REQ-019 UPDATE SHALL last 1 cycle, applying pos±1 (4-bit, no wrap), then enter DRAW.
REQ-020 DRAW and INIT_DRAW SHALL return to IDLE after PHASE_LEN cycles.
REQ-021 Move latency: an accepted edge in IDLE cycle N SHALL cause first erase Plot at N+3 and first draw Plot at N+1+47+1+2 = N+51.

Reset
REQ-022 With Reset=0 at a clock edge: state=INIT_DRAW, CurrState=HOME_POS, phase counter=0, Plot=0, Colour=3'b000, Busy=1, edge registers=0.
REQ-023 Reset mid-ERASE/DRAW SHALL abort the phase immediately; the old sprite is not erased.
REQ-024 After reset release, INIT_DRAW SHALL draw lane HOME_POS once before IDLE.

Structure
REQ-025 Shared package SHALL hold FSM state encoding, lane bounds (0, 8), HOME_POS, PHASE_LEN, and colour constants.
REQ-026 One sub-module, edge_detect (per-bit rising-edge detector), SHALL be instantiated for both inputs; all else flat.

Verification
REQ-027 Reset then release -> CurrState=4, Busy=1, 45 Plot pulses Colour=7, Busy=0 at cycle 47.
REQ-028 IDLE at lane 4, MoveRight pulse -> 45 Plot with Colour=0, CurrState=4; then 45 Plot with Colour=7, CurrState=5.
REQ-029 Lane 0, MoveLeft pulse -> no Plot, Busy stays 0, CurrState=0; lane 8 MoveRight likewise.
REQ-030 MoveLeft and MoveRight rising same cycle -> no Plot, CurrState unchanged.
REQ-031 MoveRight held high 200 cycles -> exactly one move (4->5); MoveLeft pulsed during DRAW -> ignored.
REQ-032 Reset asserted at ERASE cycle 20 -> next cycle CurrState=4, Plot=0, state INIT_DRAW.
